sramc_stream_reader: RTL and testbench
======================================

# sramc_stream_reader

Read-side drain engine for SRAM C: once partial sums have been written into SRAM C, this block reads a programmed range of SRAMC_W-bit words back and presents them, in address order, on a valid/ready stream to the DMA writer path. The SRAM has a fixed 1-cycle read latency and cannot be stalled, so the block issues reads only against guaranteed buffer space (credit-based) and absorbs stream backpressure in a small output FIFO.

## Interface
- SRAMC_W, 512, SRAM C word width (OC_W*Y); also the stream data width
- ADRC_W, 10, SRAM C address width
- FIFO_DEPTH, 2, output buffer entries (≥2)

- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_base_addr  in  ADRC_W  first SRAM C address; sampled with i_start
- i_nwords  in  ADRC_W+1  number of words to read; sampled with i_start
- o_busy  out  1  high from the cycle after accepted start until done
- o_done  out  1  single-cycle completion pulse
- o_sram_ren  out  1  SRAM C read enable
- o_sram_addr  out  ADRC_W  SRAM C read address
- i_sram_rdata  in  SRAMC_W  read data, valid the cycle after o_sram_ren
- o_tvalid  out  1  stream data valid
- i_tready  in  1  stream sink ready
- o_tdata  out  SRAMC_W  stream data (FIFO head)
- o_tlast  out  1  high with the final word of the transfer

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on i_start=1, latch base address into addr counter and i_nwords into issue and output counters. If i_nwords=0 go to DONE, else RUN. All other inputs are ignored in IDLE.
- RUN: o_sram_ren=1 when credit is available, i.e., occ + inflight − pop < FIFO_DEPTH. occ is FIFO occupancy, inflight is a read issued last cycle, and pop = o_tvalid & i_tready this cycle. Each issued read increments addr, which wraps modulo 2^ADRC_W, and decrements the issue count. When the last read is issued, go to DRAIN.
- DRAIN: no reads. Wait until the final word is popped, which is the handshake with o_tlast=1, then go to DONE.
- DONE: o_done=1 for one cycle, then return to IDLE.
- Data capture: when inflight=1, i_sram_rdata is pushed into the FIFO at the next edge. The credit rule guarantees that a push never finds the FIFO full.
- o_tlast: high when the FIFO head is word index i_nwords−1. The output counter decrements on each pop.
- i_start while o_busy=1 is ignored and does not restart or corrupt the transfer.
- o_busy=1 in RUN and DRAIN, and also in DONE.

## Timing
- Reset (async, i_rstn=0): state=IDLE. o_busy, o_done, o_sram_ren, o_tvalid and o_tlast are all 0. o_sram_addr and o_tdata are 0. FIFO is emptied and inflight is cleared, so a read in flight at reset is discarded.
- Reset mid-transfer: transfer is abandoned with no o_done, and the block is ready for i_start on the first edge after release.
- Latency: i_start at edge E0 gives o_sram_ren=1 in cycle E0+1, data captured at E0+2, and o_tvalid=1 in cycle E0+2→E0+3.
- First o_tvalid is 3 cycles after start.
- Throughput: with i_tready held at 1, 1 word/cycle sustained for FIFO_DEPTH≥2, with no bubbles.
- N words with no backpressure: the last handshake occurs at cycle E0+N+2 and o_done is high in cycle E0+N+3.
- Stream rules: o_tvalid does not depend combinationally on i_tready. While o_tvalid&!i_tready, o_tdata and o_tlast are held stable.
- Simultaneous push and pop on a full FIFO is legal and leaves occ unchanged.
- o_sram_addr holds its last value when o_sram_ren=0.
- o_done coincides with the DONE state only. o_busy falls in the same cycle that the state returns to IDLE.

## Test plan
- Basic: base=0x010, nwords=4, tready=1. Expect reads at 0x010..0x013 in 4 consecutive cycles, 4 beats in order, tlast on beat 4, o_done at start+7.
- Backpressure: nwords=8, tready toggling 1,0,0,1 pattern. Expect no data loss or duplication, o_tdata stable while stalled, and occ+inflight never exceeding FIFO_DEPTH.
- Wrap: base=0x3FE, nwords=4, ADRC_W=10. Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero length: nwords=0. Expect no o_sram_ren, no o_tvalid, o_done one cycle after start.
- Start while busy and back-to-back: a second i_start mid-transfer is ignored. A new i_start in the cycle after o_done is accepted and its data is correct.
- Reset mid-operation: assert i_rstn=0 after 3 of 8 words. Expect all outputs at 0 immediately and no o_done. A following transfer with nwords=2 completes correctly.

Source files
------------

// File: rtl/sramc_stream_reader.sv
// SRAM C drain engine: streams a programmed address range out on valid/ready.
// Reads are issued only when the output FIFO has guaranteed room for the returning word.
module sramc_stream_reader #(
   parameter int unsigned SRAMC_W    = 512,
   parameter int unsigned ADRC_W     = 10,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_start,
   input  logic [ADRC_W-1:0]   i_base_addr,
   input  logic [ADRC_W:0]     i_nwords,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_sram_ren,
   output logic [ADRC_W-1:0]   o_sram_addr,
   input  logic [SRAMC_W-1:0]  i_sram_rdata,
   output logic                o_tvalid,
   input  logic                i_tready,
   output logic [SRAMC_W-1:0]  o_tdata,
   output logic                o_tlast
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e              r_state;
   logic                r_busy;
   logic                r_done;
   logic                r_inflight;
   logic [ADRC_W-1:0]   r_addr;
   logic [ADRC_W:0]     r_icnt;
   logic [ADRC_W:0]     r_ocnt;
   logic [SRAMC_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [OCC_W-1:0]    r_occ;

   logic w_pop;
   logic w_credit;
   logic w_ren;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_tvalid = (r_occ != '0);
   assign w_pop    = o_tvalid & i_tready;
   // Room must exist for the word already in flight plus the one issued now.
   assign w_credit = (32'(r_occ) + 32'(r_inflight)) < (FIFO_DEPTH + 32'(w_pop));
   assign w_ren    = (r_state == StRun) & w_credit;

   assign o_sram_ren  = w_ren;
   assign o_sram_addr = r_addr;
   assign o_tdata     = r_mem[r_rptr];
   assign o_tlast     = o_tvalid & (r_ocnt == {{ADRC_W{1'b0}}, 1'b1});
   assign o_busy      = r_busy;
   assign o_done      = r_done;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= StIdle;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_addr  <= '0;
         r_icnt  <= '0;
         r_ocnt  <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_pop) r_ocnt <= r_ocnt - {{ADRC_W{1'b0}}, 1'b1};
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_addr <= i_base_addr;
                  r_icnt <= i_nwords;
                  r_ocnt <= i_nwords;
                  r_busy <= 1'b1;
                  if (i_nwords == '0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StRun;
                  end
               end
            end
            StRun: begin
               if (w_ren) begin
                  r_addr <= r_addr + ADRC_W'(1);
                  r_icnt <= r_icnt - {{ADRC_W{1'b0}}, 1'b1};
                  if (r_icnt == {{ADRC_W{1'b0}}, 1'b1}) r_state <= StDrain;
               end
            end
            StDrain: begin
               if (w_pop && o_tlast) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Output FIFO; a simultaneous push and pop leaves occupancy unchanged.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_inflight <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_occ      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_inflight <= w_ren;
         if (r_inflight) begin
            r_mem[r_wptr] <= i_sram_rdata;
            r_wptr        <= f_inc(r_wptr);
         end
         if (w_pop) r_rptr <= f_inc(r_rptr);
         case ({r_inflight, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: tb/tb_sramc_stream_reader.sv
// Directed bench for sramc_stream_reader: scoreboard of expected reads/beats checked by a
// negedge monitor, plus latency, wrap, zero-length, busy-start and reset scenarios.
module tb_sramc_stream_reader;

   localparam int unsigned SRAMC_W    = 512;
   localparam int unsigned ADRC_W     = 10;
   localparam int unsigned FIFO_DEPTH = 2;

   logic                i_clk = 1'b0;
   logic                i_rstn = 1'b0;
   logic                i_start = 1'b0;
   logic [ADRC_W-1:0]   i_base_addr = '0;
   logic [ADRC_W:0]     i_nwords = '0;
   logic                o_busy;
   logic                o_done;
   logic                o_sram_ren;
   logic [ADRC_W-1:0]   o_sram_addr;
   logic [SRAMC_W-1:0]  i_sram_rdata = '0;
   logic                o_tvalid;
   logic                i_tready = 1'b1;
   logic [SRAMC_W-1:0]  o_tdata;
   logic                o_tlast;

   sramc_stream_reader #(
      .SRAMC_W   (SRAMC_W),
      .ADRC_W    (ADRC_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_nwords    (i_nwords),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_sram_ren  (o_sram_ren),
      .o_sram_addr (o_sram_addr),
      .i_sram_rdata(i_sram_rdata),
      .o_tvalid    (o_tvalid),
      .i_tready    (i_tready),
      .o_tdata     (o_tdata),
      .o_tlast     (o_tlast)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [SRAMC_W-1:0] d;
      logic               last;
   } beat_t;

   beat_t            exp_beat[$];
   logic [ADRC_W-1:0] exp_addr[$];
   int n_chk = 0, n_pass = 0, n_beats = 0, n_ren = 0, out_cnt = 0;

   function automatic logic [SRAMC_W-1:0] pat(input logic [ADRC_W-1:0] a);
      logic [SRAMC_W-1:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = {a, 6'(k), 16'hC3A5 ^ {6'd0, a}};
      return r;
   endfunction

   // SRAM model: 1-cycle read latency, garbage when not reading.
   always @(posedge i_clk) i_sram_rdata <= o_sram_ren ? pat(o_sram_addr) : {16{32'hDEADBEEF}};

   task automatic chk(input string tag, input logic [SRAMC_W-1:0] got,
                      input logic [SRAMC_W-1:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor: scoreboard reads/beats, stall stability, credit bound.
   logic               prev_stall = 1'b0;
   logic [SRAMC_W-1:0] prev_data;
   logic               prev_last;
   beat_t              mb;
   always @(negedge i_clk) begin
      if (!i_rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_tvalid", o_tvalid, 1);
            chk("stall_tdata", o_tdata, prev_data);
            chk("stall_tlast", o_tlast, prev_last);
         end
         if (o_sram_ren) begin
            n_ren++;
            chk("rd_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) chk("rd_addr", o_sram_addr, exp_addr.pop_front());
         end
         if (o_tvalid && i_tready) begin
            n_beats++;
            chk("beat_expected", exp_beat.size() != 0, 1);
            if (exp_beat.size() != 0) begin
               mb = exp_beat.pop_front();
               chk("tdata", o_tdata, mb.d);
               chk("tlast", o_tlast, mb.last);
            end
         end
         out_cnt = out_cnt + int'(o_sram_ren) - int'(o_tvalid && i_tready);
         chk("credit_bound", out_cnt <= int'(FIFO_DEPTH), 1);
         prev_stall = o_tvalid && !i_tready;
         prev_data  = o_tdata;
         prev_last  = o_tlast;
      end
   end

   // Call at a negedge; start is sampled at the following posedge.
   task automatic start(input logic [ADRC_W-1:0] base, input int n);
      logic [ADRC_W-1:0] a;
      chk("start_idle_busy", o_busy, 0);
      i_start = 1'b1;
      i_base_addr = base;
      i_nwords = 11'(n);
      for (int i = 0; i < n; i++) begin
         a = base + 10'(i);
         exp_addr.push_back(a);
         exp_beat.push_back('{d: pat(a), last: (i == n - 1)});
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_base_addr = 10'h155;
      i_nwords = 11'd5;
   endtask

   // idx numbers cycles after the start edge: idx k is the cycle ending at edge E0+k.
   task automatic run(input bit bp, input int spur_at, output int done_idx, output int first_tv);
      bit tr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      done_idx = -1;
      first_tv = -1;
      for (int idx = 1; idx <= 300; idx++) begin
         @(negedge i_clk);
         if (o_tvalid && first_tv < 0) first_tv = idx;
         if (o_done) begin
            done_idx = idx;
            chk("done_busy", o_busy, 1);
            break;
         end
         @(posedge i_clk);
         #1;
         i_tready = bp ? tr_pat[idx % 4] : 1'b1;
         i_start = (idx == spur_at);
         if (idx == spur_at) begin
            i_base_addr = 10'h200;
            i_nwords = 11'd3;
         end
      end
      i_tready = 1'b1;
      i_start = 1'b0;
      chk("done_seen", done_idx > 0, 1);
   endtask

   task automatic post_check(input string tag);
      @(negedge i_clk);
      chk({tag, "_done_pulse"}, o_done, 0);
      chk({tag, "_idle_busy"}, o_busy, 0);
      chk({tag, "_rd_sb_empty"}, exp_addr.size(), 0);
      chk({tag, "_beat_sb_empty"}, exp_beat.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_ren"}, o_sram_ren, 0);
      chk({tag, "_tvalid"}, o_tvalid, 0);
      chk({tag, "_tlast"}, o_tlast, 0);
      chk({tag, "_addr"}, o_sram_addr, 0);
      chk({tag, "_tdata"}, o_tdata, 0);
   endtask

   initial begin
      int d, ft, r0, b0;
      bit reached, saw_done;

      #1;
      check_zero_outputs("reset");
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;

      // Basic: 4 words, no backpressure.
      @(negedge i_clk);
      r0 = n_ren; b0 = n_beats;
      start(10'h010, 4);
      run(1'b0, -1, d, ft);
      chk("basic_done_cycle", d, 7);
      chk("basic_first_tvalid", ft, 3);
      chk("basic_reads", n_ren - r0, 4);
      chk("basic_beats", n_beats - b0, 4);
      post_check("basic");

      // Wrap across the top of the address space.
      @(negedge i_clk);
      r0 = n_ren;
      start(10'h3FE, 4);
      run(1'b0, -1, d, ft);
      chk("wrap_done_cycle", d, 7);
      chk("wrap_reads", n_ren - r0, 4);
      post_check("wrap");

      // Zero length.
      @(negedge i_clk);
      r0 = n_ren; b0 = n_beats;
      start(10'h100, 0);
      run(1'b0, -1, d, ft);
      chk("zero_done_cycle", d, 1);
      chk("zero_no_reads", n_ren - r0, 0);
      chk("zero_no_beats", n_beats - b0, 0);
      post_check("zero");

      // Backpressure with a spurious start mid-transfer, then back-to-back start.
      @(negedge i_clk);
      b0 = n_beats;
      start(10'h080, 8);
      run(1'b1, 4, d, ft);
      chk("bp_beats", n_beats - b0, 8);
      @(negedge i_clk);
      b0 = n_beats;
      start(10'h040, 3);
      run(1'b0, -1, d, ft);
      chk("b2b_done_cycle", d, 6);
      chk("b2b_beats", n_beats - b0, 3);
      post_check("b2b");

      // Reset mid-transfer after three beats.
      @(negedge i_clk);
      b0 = n_beats;
      start(10'h300, 8);
      reached = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge i_clk);
         if (o_done) saw_done = 1'b1;
         if (n_beats - b0 >= 3) begin
            reached = 1'b1;
            break;
         end
      end
      chk("rst_beats_reached", reached, 1);
      i_rstn = 1'b0;
      #1;
      check_zero_outputs("midrst");
      exp_addr.delete();
      exp_beat.delete();
      out_cnt = 0;
      repeat (2) @(negedge i_clk);
      if (o_done) saw_done = 1'b1;
      chk("midrst_no_done", saw_done, 0);
      i_rstn = 1'b1;
      b0 = n_beats;
      start(10'h020, 2);
      run(1'b0, -1, d, ft);
      chk("after_rst_done_cycle", d, 5);
      chk("after_rst_beats", n_beats - b0, 2);
      post_check("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
